// File: rtl/br_lite_ni_pkg.sv
// Shared types for the BrLite PE network interface: flit layout, service codes and FSM states.
package br_lite_ni_pkg;

  localparam int unsigned BR_ID_W      = 5;
  localparam int unsigned BR_XY_W      = 16;
  localparam int unsigned BR_PAYLOAD_W = 16;

  typedef enum logic {
    BR_SVC_ALL = 1'b0,
    BR_SVC_TGT = 1'b1
  } br_svc_t;

  typedef struct packed {
    logic [BR_XY_W-1:0]      source;
    logic [BR_XY_W-1:0]      target;
    logic [BR_PAYLOAD_W-1:0] payload;
    br_svc_t                 svc;
    logic [BR_ID_W-1:0]      id;
  } br_data_t;

  typedef enum logic [1:0] {
    TxIdle,
    TxReq,
    TxDrain
  } tx_state_t;

  typedef enum logic {
    RxWait,
    RxAck
  } rx_state_t;

endpackage

// File: rtl/br_lite_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is dropped even if a pop
// happens in the same cycle.
module br_lite_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/br_lite_ni.sv
// PE-side BrLite network interface: TX FIFO + req/ack injector, RX 4-phase acceptor + FIFO.
module br_lite_ni
  import br_lite_ni_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BR_XY_W-1:0]        local_xy_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  input  logic [BR_XY_W-1:0]        tx_target_i,
  input  logic [BR_PAYLOAD_W-1:0]   tx_payload_i,
  input  br_svc_t                   tx_svc_i,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output br_data_t                  rx_flit_o,
  output br_data_t                  noc_flit_o,
  output logic                      noc_req_o,
  input  logic                      noc_ack_i,
  input  logic                      noc_busy_i,
  input  br_data_t                  noc_flit_i,
  input  logic                      noc_req_i,
  output logic                      noc_ack_o,
  output logic [$clog2(TX_DEPTH):0] tx_pending_o
);

  tx_state_t                tx_state_q;
  rx_state_t                rx_state_q;
  logic [BR_ID_W-1:0]       id_cnt_q;
  br_data_t                 tx_wdata, tx_head, rx_head;
  logic                     tx_push, tx_pop, tx_full, tx_empty;
  logic                     rx_push, rx_pop, rx_full, rx_empty;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic                     unused_rx_count;

  assign unused_rx_count = ^rx_count;

  // TX side
  assign tx_ready_o = ~tx_full;
  assign tx_push    = tx_valid_i & ~tx_full;
  assign tx_pop     = (tx_state_q == TxReq) & noc_ack_i;
  assign tx_wdata   = '{source:  local_xy_i,
                        target:  tx_target_i,
                        payload: tx_payload_i,
                        svc:     tx_svc_i,
                        id:      id_cnt_q};
  // Head is only driven while requesting so the link idles at zero.
  assign noc_flit_o = noc_req_o ? tx_head : '0;

  br_lite_fifo #(
    .T     (br_data_t),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .wdata (tx_wdata),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_pending_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_cnt_q <= '0;
    end else if (tx_push) begin
      id_cnt_q <= id_cnt_q + BR_ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TxIdle;
      noc_req_o  <= 1'b0;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          // busy only blocks starting a new injection, never an ongoing one
          if (!tx_empty && !noc_busy_i) begin
            tx_state_q <= TxReq;
            noc_req_o  <= 1'b1;
          end
        end
        TxReq: begin
          if (noc_ack_i) begin
            tx_state_q <= TxDrain;
            noc_req_o  <= 1'b0;
          end
        end
        TxDrain: begin
          if (!noc_ack_i) tx_state_q <= TxIdle;
        end
        default: begin
          tx_state_q <= TxIdle;
          noc_req_o  <= 1'b0;
        end
      endcase
    end
  end

  // RX side
  assign rx_push    = (rx_state_q == RxWait) & noc_req_i & ~rx_full;
  assign rx_valid_o = ~rx_empty;
  assign rx_pop     = rx_valid_o & rx_ready_i;
  assign rx_flit_o  = rx_valid_o ? rx_head : '0;

  br_lite_fifo #(
    .T     (br_data_t),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .wdata (noc_flit_i),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RxWait;
      noc_ack_o  <= 1'b0;
    end else begin
      unique case (rx_state_q)
        RxWait: begin
          if (rx_push) begin
            rx_state_q <= RxAck;
            noc_ack_o  <= 1'b1;
          end
        end
        RxAck: begin
          if (!noc_req_i) begin
            rx_state_q <= RxWait;
            noc_ack_o  <= 1'b0;
          end
        end
        default: begin
          rx_state_q <= RxWait;
          noc_ack_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
